pdm_frame_packer: RTL and testbench

Collects per-channel accumulator words from the PDM decimation stage and packs them into fixed-order byte frames in a small FIFO. It drives a UART transmitter through a valid/ready handshake, so bytes are never lost to a busy transmitter. It sits between the accumulator outputs (`accum_recv` instances) and `rs232_comms`. Whole frames are dropped and counted when buffer space runs out.

---
 rtl/pdm_frame_packer.sv | 158 +++++++++++++++
 tb/tb_pdm_frame_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_frame_packer.sv
// rtl/pdm_frame_packer.sv - packs per-channel accumulator words into byte frames for a UART
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   ch_valid[NUM_CH]       one-cycle strobe per channel
//   ch_data                channel i word at [i*ACCUM_BITS +: ACCUM_BITS]
//   tx_byte, tx_valid      FIFO head byte and its valid flag
//   tx_ready               transmitter accepts tx_byte this cycle
//   overflow               sticky, set on the first dropped frame
//   drop_count             dropped frames, saturating at 255
//   fifo_level             bytes currently stored

module pdm_frame_packer #(
    parameter int NUM_CH     = 4,
    parameter int ACCUM_BITS = 5,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*ACCUM_BITS-1:0] ch_data,
    output logic [7:0]                   tx_byte,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         overflow,
    output logic [7:0]                   drop_count,
    output logic [$clog2(DEPTH):0]       fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      cap   [NUM_CH];
    logic [7:0]      frame [NUM_CH];
    logic [NUM_CH-1:0] have;
    logic [7:0]      mem   [DEPTH];
    logic [LW-1:0]   wr_ptr, rd_ptr, rd_ptr_n, level_n, space;
    logic            commit, room, wr_en, pop;
    logic [7:0]      wr_data, tx_byte_d;

    assign commit     = (state_q == IDLE) && (&have);
    assign fifo_level = wr_ptr - rd_ptr;
    assign space      = LW'(DEPTH) - fifo_level;
    assign room       = (space >= LW'(NUM_CH));
    assign tx_valid   = (fifo_level != '0);
    assign pop        = tx_valid && tx_ready;

    // Capture: a strobe in the commit cycle wins over the clear, so that
    // word belongs to the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cap[i]   <= 8'h00;
                frame[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit) begin
                    frame[i] <= cap[i];
                end
                if (ch_valid[i]) begin
                    cap[i]  <= {3'(i), 5'(ch_data[i*ACCUM_BITS +: ACCUM_BITS])};
                    have[i] <= 1'b1;
                end else if (commit) begin
                    have[i] <= 1'b0;
                end
            end
        end
    end

    // Drop accounting for frames that fail the space check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else if (commit && !room) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'h01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Loader: writes the frame highest channel first, one byte per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_data = frame[idx_q];
        case (state_q)
            IDLE: begin
                if (commit && room) begin
                    state_d = LOAD;
                    idx_d   = IW'(NUM_CH - 1);
                end
            end
            LOAD: begin
                wr_en = 1'b1;
                if (idx_q == '0) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // tx_byte is registered with the head that will exist after this edge;
    // a byte written straight into an empty head is forwarded so it shows
    // one cycle after its write.
    always_comb begin
        rd_ptr_n = rd_ptr + LW'(pop);
        level_n  = wr_ptr + LW'(wr_en) - rd_ptr_n;
        if (level_n == '0) begin
            tx_byte_d = 8'h00;
        end else if (wr_en && (wr_ptr == rd_ptr_n)) begin
            tx_byte_d = wr_data;
        end else begin
            tx_byte_d = mem[rd_ptr_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tx_byte <= 8'h00;
        end else begin
            wr_ptr  <= wr_ptr + LW'(wr_en);
            rd_ptr  <= rd_ptr_n;
            tx_byte <= tx_byte_d;
        end
    end

endmodule

// File: tb/tb_pdm_frame_packer.sv
// tb/tb_pdm_frame_packer.sv - scoreboard bench for pdm_frame_packer

module tb_pdm_frame_packer;

    localparam int NUM_CH = 4;
    localparam int AB     = 5;
    localparam int DEPTH  = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_CH-1:0]    ch_valid = '0;
    logic [NUM_CH*AB-1:0] ch_data = '0;
    logic [7:0]           tx_byte;
    logic                 tx_valid;
    logic                 tx_ready = 1'b0;
    logic                 overflow;
    logic [7:0]           drop_count;
    logic [4:0]           fifo_level;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    pdm_frame_packer #(.NUM_CH(NUM_CH), .ACCUM_BITS(AB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mk_byte(input int ch, input logic [4:0] d);
        return {3'(ch), d};
    endfunction

    // Strobes every channel in one cycle; returns one #1 after edge C.
    task automatic send_frame(input logic [NUM_CH*AB-1:0] d, input bit accepted);
        if (accepted) begin
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                sb_q.push_back(mk_byte(c, d[c*AB +: AB]));
            end
        end
        ch_valid = '1;
        ch_data  = d;
        step();
        ch_valid = '0;
    endtask

    task automatic strobe_ch(input int ch, input logic [4:0] d);
        ch_valid     = '0;
        ch_valid[ch] = 1'b1;
        ch_data      = '0;
        ch_data[ch*AB +: AB] = d;
        step();
        ch_valid = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || fifo_level != 0) && n < 400) begin
            step();
            n++;
        end
        check("drain_done", {31'd0, (sb_q.size() == 0 && fifo_level == 0)}, 32'd1);
    endtask

    function automatic logic [NUM_CH*AB-1:0] rand_frame();
        logic [NUM_CH*AB-1:0] d;
        for (int c = 0; c < NUM_CH; c++) d[c*AB +: AB] = 5'($urandom_range(0, 31));
        return d;
    endfunction

    // Scoreboard consumer: every accepted byte must match the queue head.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            check("byte_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                check("tx_byte", {24'd0, tx_byte}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop_count", {24'd0, drop_count}, 32'd0);
        check("rst_fifo_level", {27'd0, fifo_level}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic frame with first-byte latency
        tx_ready = 1'b1;
        send_frame({5'd8, 5'd7, 5'd6, 5'd5}, 1'b1);
        step();
        check("basic_c1_valid", {31'd0, tx_valid}, 32'd0);
        step();
        check("basic_c2_valid", {31'd0, tx_valid}, 32'd1);
        check("basic_c2_byte", {24'd0, tx_byte}, 32'h68);
        wait_drain();

        // Staggered strobes with ch0 overwritten
        strobe_ch(0, 5'd3);
        strobe_ch(0, 5'd9);
        strobe_ch(1, 5'd1);
        strobe_ch(2, 5'd2);
        sb_q.push_back(mk_byte(3, 5'd4));
        sb_q.push_back(mk_byte(2, 5'd2));
        sb_q.push_back(mk_byte(1, 5'd1));
        sb_q.push_back(8'h09);
        strobe_ch(3, 5'd4);
        wait_drain();
        repeat (10) step();
        check("stagger_one_frame", {27'd0, fifo_level}, 32'd0);

        // Backpressure and overflow
        tx_ready = 1'b0;
        for (int f = 0; f < 5; f++) begin
            send_frame(rand_frame(), f < 4);
            repeat (NUM_CH + 2) step();
        end
        check("bp_level", {27'd0, fifo_level}, 32'd16);
        check("bp_drop_count", {24'd0, drop_count}, 32'd1);
        check("bp_overflow", {31'd0, overflow}, 32'd1);
        check("bp_queued", sb_q.size(), 32'd16);
        tx_ready = 1'b1;
        wait_drain();

        // Commit during LOAD: second frame loads right after the first
        tx_ready = 1'b0;
        send_frame(rand_frame(), 1'b1);
        step();
        send_frame(rand_frame(), 1'b1);
        repeat (4) step();
        check("cdl_level_c6", {27'd0, fifo_level}, 32'd4);
        step();
        check("cdl_level_c7", {27'd0, fifo_level}, 32'd5);
        repeat (3) step();
        check("cdl_level_c10", {27'd0, fifo_level}, 32'd8);
        tx_ready = 1'b1;
        wait_drain();

        // Reset mid-LOAD
        tx_ready = 1'b0;
        send_frame(rand_frame(), 1'b0);
        repeat (3) step();
        check("mid_load_level", {27'd0, fifo_level}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("arst_tx_byte", {24'd0, tx_byte}, 32'h00);
        check("arst_fifo_level", {27'd0, fifo_level}, 32'd0);
        check("arst_overflow", {31'd0, overflow}, 32'd0);
        check("arst_drop_count", {24'd0, drop_count}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        tx_ready = 1'b1;
        send_frame({5'd31, 5'd0, 5'd17, 5'd10}, 1'b1);
        wait_drain();

        // Saturation of drop_count
        tx_ready = 1'b0;
        for (int f = 0; f < 4; f++) begin
            send_frame(rand_frame(), 1'b1);
            repeat (NUM_CH + 2) step();
        end
        check("sat_full", {27'd0, fifo_level}, 32'd16);
        for (int f = 0; f < 254; f++) begin
            send_frame(rand_frame(), 1'b0);
            step();
        end
        check("sat_254", {24'd0, drop_count}, 32'd254);
        send_frame(rand_frame(), 1'b0);
        step();
        check("sat_255", {24'd0, drop_count}, 32'd255);
        for (int f = 0; f < 45; f++) begin
            send_frame(rand_frame(), 1'b0);
            step();
        end
        check("sat_hold", {24'd0, drop_count}, 32'd255);
        check("sat_overflow", {31'd0, overflow}, 32'd1);
        tx_ready = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
